// File: rtl/sumador_serial_pkg.sv
// Shared types and constants for the bit-serial adder.
// State encoding is fixed so waveforms and debug tools agree on values.
package sumador_serial_pkg;

    localparam int ANCHO_DEF = 8;

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        CALCULO = 2'd1,
        FIN     = 2'd2
    } estado_t;

    // Bit counter width: clog2(ancho), never narrower than one bit.
    function automatic int ancho_contador(input int ancho);
        return (ancho > 1) ? $clog2(ancho) : 1;
    endfunction

endpackage

// File: rtl/sumador_serial_if.sv
// Start/operand/result bundle of the bit-serial adder.
// master drives the request and reads the result; slave is the adder.
interface sumador_serial_if
    import sumador_serial_pkg::*;
#(
    parameter int ANCHO = ANCHO_DEF
) ();

    logic             inicio;
    logic [ANCHO-1:0] x;
    logic [ANCHO-1:0] y;
    logic             acarreo_entrada;
    logic [ANCHO-1:0] suma;
    logic             acarreo_salida;
    logic             ocupado;
    logic             listo;

    modport master (
        output inicio, x, y, acarreo_entrada,
        input  suma, acarreo_salida, ocupado, listo
    );

    modport slave (
        input  inicio, x, y, acarreo_entrada,
        output suma, acarreo_salida, ocupado, listo
    );

endinterface

// File: rtl/sumador_serial_sumador_completo.sv
// Combinational one-bit full adder cell fed by the serial adder.
// Zero latency; no flow control.
module Sumador_Completo (
    input  logic X,
    input  logic Y,
    input  logic AcarreoEntrada,
    output logic Salida,
    output logic AcarreoSalida
);

    assign Salida        = X ^ Y ^ AcarreoEntrada;
    assign AcarreoSalida = (X & Y) | (X & AcarreoEntrada) | (Y & AcarreoEntrada);

endmodule

// File: rtl/sumador_serial.sv
// Bit-serial ANCHO-bit adder: one full-adder cell, LSB first, one bit per clock.
// Result and one-cycle listo land ANCHO cycles after the accepted start edge.
module sumador_serial
    import sumador_serial_pkg::*;
#(
    parameter int ANCHO = ANCHO_DEF
) (
    input  logic             clk,
    input  logic             rst,
    sumador_serial_if.slave  bus
);

    localparam int             CW     = ancho_contador(ANCHO);
    localparam logic [CW-1:0]  ULTIMO = CW'(ANCHO - 1);

    estado_t          estado_q, estado_d;
    logic [ANCHO-1:0] reg_x_q, reg_x_d;
    logic [ANCHO-1:0] reg_y_q, reg_y_d;
    logic [ANCHO-1:0] acc_q, acc_d;
    logic [ANCHO-1:0] suma_q, suma_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ocupado_q, ocupado_d;
    logic             listo_q, listo_d;

    logic             bit_suma;
    logic             bit_carry;
    logic [ANCHO-1:0] acc_sig;
    logic             arranque;

    Sumador_Completo u_celda (
        .X              (reg_x_q[0]),
        .Y              (reg_y_q[0]),
        .AcarreoEntrada (carry_q),
        .Salida         (bit_suma),
        .AcarreoSalida  (bit_carry)
    );

    // Sum bits enter at the MSB so after ANCHO shifts the word is aligned.
    assign acc_sig  = (acc_q >> 1) | (ANCHO'(bit_suma) << (ANCHO - 1));
    assign arranque = bus.inicio && ((estado_q == REPOSO) || (estado_q == FIN));

    always_comb begin
        estado_d  = estado_q;
        reg_x_d   = reg_x_q;
        reg_y_d   = reg_y_q;
        acc_d     = acc_q;
        suma_d    = suma_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        ocupado_d = ocupado_q;
        listo_d   = 1'b0;

        case (estado_q)
            REPOSO, FIN: begin
                if (arranque) begin
                    reg_x_d   = bus.x;
                    reg_y_d   = bus.y;
                    carry_d   = bus.acarreo_entrada;
                    acc_d     = '0;
                    cnt_d     = '0;
                    ocupado_d = 1'b1;
                    estado_d  = CALCULO;
                end else begin
                    estado_d  = REPOSO;
                end
            end
            CALCULO: begin
                reg_x_d = reg_x_q >> 1;
                reg_y_d = reg_y_q >> 1;
                acc_d   = acc_sig;
                carry_d = bit_carry;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == ULTIMO) begin
                    suma_d    = acc_sig;
                    cout_d    = bit_carry;
                    listo_d   = 1'b1;
                    ocupado_d = 1'b0;
                    estado_d  = FIN;
                end
            end
            default: estado_d = REPOSO;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q  <= REPOSO;
            reg_x_q   <= '0;
            reg_y_q   <= '0;
            acc_q     <= '0;
            suma_q    <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
            ocupado_q <= 1'b0;
            listo_q   <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            reg_x_q   <= reg_x_d;
            reg_y_q   <= reg_y_d;
            acc_q     <= acc_d;
            suma_q    <= suma_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            cout_q    <= cout_d;
            ocupado_q <= ocupado_d;
            listo_q   <= listo_d;
        end
    end

    assign bus.suma           = suma_q;
    assign bus.acarreo_salida = cout_q;
    assign bus.ocupado        = ocupado_q;
    assign bus.listo          = listo_q;

endmodule

// File: tb/tb_sumador_serial.sv
// Scoreboard bench for sumador_serial at ANCHO=8 and ANCHO=1.
// Drivers push expected {suma, carry, cycle}; per-DUT monitors pop on listo.
module tb_sumador_serial;
    import sumador_serial_pkg::*;

    typedef struct {
        logic [7:0] s;
        logic       c;
        int         ciclo;
    } esp8_t;

    typedef struct {
        logic s;
        logic c;
        int   ciclo;
    } esp1_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sumador_serial_if #(.ANCHO(8)) bus8 ();
    sumador_serial_if #(.ANCHO(1)) bus1 ();

    sumador_serial #(.ANCHO(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    sumador_serial #(.ANCHO(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int    errors = 0;
    int    checks = 0;
    esp8_t q8[$];
    esp1_t q1[$];
    logic [7:0] ult_s8 = 8'h00;
    logic       ult_c8 = 1'b0;
    logic       ult_s1 = 1'b0;
    logic       ult_c1 = 1'b0;
    int    listos8 = 0;

    task automatic chk(input string nombre, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nombre, act, req, cyc);
        end
    endtask

    // Results must appear exactly when predicted and hold steady while busy.
    always @(negedge clk) begin
        esp8_t e;
        if (!rst) begin
            if (bus8.listo) begin
                listos8++;
                checks++;
                if (q8.size() == 0) begin
                    errors++;
                    $display("FAIL listo8_unexpected: got listo with empty queue at cycle %0d", cyc);
                end else begin
                    e = q8.pop_front();
                    chk("suma8", bus8.suma, e.s);
                    chk("cout8", bus8.acarreo_salida, e.c);
                    chk("latency8", cyc, e.ciclo);
                    chk("ocupado8_at_listo", bus8.ocupado, 0);
                    ult_s8 = e.s;
                    ult_c8 = e.c;
                end
            end else if (bus8.ocupado) begin
                chk("hold8", {bus8.acarreo_salida, bus8.suma}, {ult_c8, ult_s8});
            end
        end
    end

    always @(negedge clk) begin
        esp1_t e;
        if (!rst) begin
            if (bus1.listo) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL listo1_unexpected: got listo with empty queue at cycle %0d", cyc);
                end else begin
                    e = q1.pop_front();
                    chk("suma1", bus1.suma, e.s);
                    chk("cout1", bus1.acarreo_salida, e.c);
                    chk("latency1", cyc, e.ciclo);
                    ult_s1 = e.s;
                    ult_c1 = e.c;
                end
            end else if (bus1.ocupado) begin
                chk("hold1", {bus1.acarreo_salida, bus1.suma}, {ult_c1, ult_s1});
            end
        end
    end

    task automatic arranca8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                            input logic [7:0] s, input logic c);
        esp8_t e;
        @(negedge clk);
        bus8.inicio = 1'b1;
        bus8.x = a;
        bus8.y = b;
        bus8.acarreo_entrada = ci;
        e.s = s; e.c = c; e.ciclo = cyc + 1 + 8;
        q8.push_back(e);
        @(negedge clk);
        bus8.inicio = 1'b0;
        bus8.x = 8'($urandom);
        bus8.y = 8'($urandom);
        bus8.acarreo_entrada = 1'($urandom);
    endtask

    task automatic arranca1(input logic a, input logic b, input logic ci);
        esp1_t e;
        logic [1:0] r;
        r = 2'(a) + 2'(b) + 2'(ci);
        @(negedge clk);
        bus1.inicio = 1'b1;
        bus1.x = a;
        bus1.y = b;
        bus1.acarreo_entrada = ci;
        e.s = r[0]; e.c = r[1]; e.ciclo = cyc + 1 + 1;
        q1.push_back(e);
        @(negedge clk);
        bus1.inicio = 1'b0;
        bus1.x = ~a;
        bus1.y = ~b;
        bus1.acarreo_entrada = ~ci;
    endtask

    task automatic espera8();
        int n = 0;
        while (q8.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (q8.size() != 0) begin
            chk("timeout8", q8.size(), 0);
            q8.delete();
        end
    endtask

    task automatic espera1();
        int n = 0;
        while (q1.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        if (q1.size() != 0) begin
            chk("timeout1", q1.size(), 0);
            q1.delete();
        end
    endtask

    initial begin
        esp8_t e;
        int    n;
        logic [8:0] r9;
        logic [7:0] a, b;
        logic       ci;

        bus8.inicio = 1'b0; bus8.x = '0; bus8.y = '0; bus8.acarreo_entrada = 1'b0;
        bus1.inicio = 1'b0; bus1.x = '0; bus1.y = '0; bus1.acarreo_entrada = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_suma8", bus8.suma, 0);
        chk("rst_cout8", bus8.acarreo_salida, 0);
        chk("rst_ocupado8", bus8.ocupado, 0);
        chk("rst_listo8", bus8.listo, 0);
        chk("rst_listo1", bus1.listo, 0);
        rst = 1'b0;

        // Basic add with ocupado window: high for the 8 cycles after the start edge.
        arranca8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        chk("ocupado_window", bus8.ocupado, 1);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("ocupado_window", bus8.ocupado, 1);
        end
        espera8();

        arranca8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        espera8();
        arranca8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        espera8();

        // inicio during CALCULO must be ignored.
        n = listos8;
        arranca8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0);
        repeat (2) @(negedge clk);
        bus8.inicio = 1'b1; bus8.x = 8'hAA; bus8.y = 8'h55;
        @(negedge clk);
        bus8.inicio = 1'b0;
        espera8();
        repeat (12) @(negedge clk);
        chk("single_listo", listos8 - n, 1);

        // Asynchronous reset mid-operation discards the add.
        arranca8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_suma", bus8.suma, 0);
        chk("async_ocupado", bus8.ocupado, 0);
        chk("async_listo", bus8.listo, 0);
        q8.delete();
        ult_s8 = 8'h00; ult_c8 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n = listos8;
        repeat (12) @(negedge clk);
        chk("no_listo_after_rst", listos8 - n, 0);
        arranca8(8'h03, 8'h04, 1'b0, 8'h07, 1'b0);
        espera8();

        // Held inicio: back-to-back starts every 9 cycles.
        @(negedge clk);
        bus8.inicio = 1'b1; bus8.x = 8'h01; bus8.y = 8'h01; bus8.acarreo_entrada = 1'b0;
        e.s = 8'h02; e.c = 1'b0; e.ciclo = cyc + 9;
        q8.push_back(e);
        repeat (9) @(negedge clk);
        bus8.x = 8'h80; bus8.y = 8'h80;
        e.s = 8'h00; e.c = 1'b1; e.ciclo = cyc + 9;
        q8.push_back(e);
        @(negedge clk);
        bus8.inicio = 1'b0;
        espera8();

        // Random sweep on both widths in parallel.
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    a  = 8'($urandom);
                    b  = 8'($urandom);
                    ci = 1'($urandom);
                    r9 = 9'(a) + 9'(b) + 9'(ci);
                    arranca8(a, b, ci, r9[7:0], r9[8]);
                    espera8();
                end
            end
            begin
                for (int j = 0; j < 1000; j++) begin
                    arranca1(1'($urandom), 1'($urandom), 1'($urandom));
                    espera1();
                end
            end
        join

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
